// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the program counter, issues sequential
// reads to the synchronous program ROM and buffers bytes for the CU.
module instr_fetch_unit #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [7:0]        debug
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_inflight;
  logic              r_drop;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

  logic [CNT_W-1:0]  w_occupancy;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  // Issue only when every outstanding byte is guaranteed a FIFO slot.
  always_comb begin
    w_occupancy = r_count + CNT_W'(r_inflight);
    w_issue     = !reset && !branch_valid && (w_occupancy < CNT_W'(DEPTH));
    w_push      = r_inflight && !r_drop;
    w_pop       = instr_valid && instr_ready && !branch_valid;
  end

  assign mem_en      = w_issue;
  assign mem_addr    = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr_data  = r_data_mem[r_rd_ptr];
  assign instr_pc    = r_pc_mem[r_rd_ptr];
  assign debug       = 8'(r_fetch_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (branch_valid) begin
      // Flush everything; a response still owed to the ROM gets discarded.
      r_fetch_pc <= branch_target;
      r_inflight <= 1'b0;
      r_drop     <= r_inflight;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      r_drop     <= 1'b0;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        r_req_addr <= r_fetch_pc;
      end
      if (w_push) begin
        r_data_mem[r_wr_ptr] <= mem_rdata;
        r_pc_mem[r_wr_ptr]   <= r_req_addr;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural ROM (ROM[a] = a + 0x10).
module tb_instr_fetch_unit;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic [7:0]        debug;

  int n_assert = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .debug(debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [7:0] a);
    return a + 8'h10;
  endfunction

  // Synchronous ROM, one cycle of read latency
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_en) mem_rdata <= rom(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A push into a full FIFO that is not relieved by a pop is an overflow.
  always @(negedge clk) begin
    if (!reset && !branch_valid)
      chk("no_overflow",
          32'(dut.w_push && !dut.w_pop && (dut.r_count == 3'(DEPTH))), 32'd0);
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    adv();
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_data",   32'(instr_data), 32'd0);
    chk("rst_pc",     32'(instr_pc), 32'd0);
    chk("rst_debug",  32'(debug), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    instr_ready   = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    adv();

    // Streaming from reset with ready held high
    do_reset();
    instr_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) adv();
      #1;
      chk("t1_mem_en", 32'(mem_en), 32'd1);
      chk("t1_addr",   32'(mem_addr), 32'(c));
      chk("t1_debug",  32'(debug), 32'(c));
      chk("t1_valid",  32'(instr_valid), 32'(c >= 2));
      if (c >= 2) begin
        chk("t1_data", 32'(instr_data), 32'(8'(8'h10 + c - 2)));
        chk("t1_pc",   32'(instr_pc), 32'(c - 2));
      end
    end

    // Stall: exactly DEPTH issues, then drain in order and resume at 04
    do_reset();
    instr_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) adv();
      #1;
      chk("t2_mem_en", 32'(mem_en), 32'(c < 4));
      chk("t2_addr",   32'(mem_addr), 32'((c < 4) ? c : 4));
      chk("t2_valid",  32'(instr_valid), 32'(c >= 2));
      if (c >= 2) begin
        chk("t2_head_data", 32'(instr_data), 32'h10);
        chk("t2_head_pc",   32'(instr_pc), 32'h00);
      end
    end
    for (int c = 10; c < 16; c++) begin
      adv();
      instr_ready = 1'b1;
      #1;
      chk("t2_valid_drain", 32'(instr_valid), 32'd1);
      chk("t2_data_drain",  32'(instr_data), 32'(8'h10 + c - 10));
      chk("t2_pc_drain",    32'(instr_pc), 32'(c - 10));
      if (c == 10) chk("t2_no_credit", 32'(mem_en), 32'd0);
      if (c == 11) chk("t2_resume_addr", 32'(mem_addr), 32'h04);
      if (c == 12) chk("t2_resume_addr2", 32'(mem_addr), 32'h05);
    end

    // Branch with 3 bytes buffered and one read in flight
    do_reset();
    instr_ready = 1'b0;
    for (int c = 1; c < 4; c++) adv();
    adv();
    branch_valid  = 1'b1;
    branch_target = 8'h80;
    #1;
    chk("t3_pre_valid", 32'(instr_valid), 32'd1);
    chk("t3_br_mem_en", 32'(mem_en), 32'd0);
    adv();
    branch_valid = 1'b0;
    instr_ready  = 1'b1;
    #1;
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_issue_en",    32'(mem_en), 32'd1);
    chk("t3_issue_addr",  32'(mem_addr), 32'h80);
    chk("t3_debug",       32'(debug), 32'h80);
    adv(); #1;
    chk("t3_valid_t2",    32'(instr_valid), 32'd0);
    chk("t3_addr_t2",     32'(mem_addr), 32'h81);
    adv(); #1;
    chk("t3_valid_t3",    32'(instr_valid), 32'd1);
    chk("t3_data_t3",     32'(instr_data), 32'h90);
    chk("t3_pc_t3",       32'(instr_pc), 32'h80);
    adv(); #1;
    chk("t3_data_t4",     32'(instr_data), 32'h91);
    chk("t3_pc_t4",       32'(instr_pc), 32'h81);

    // Back-to-back branches: only the later target is ever delivered
    adv();
    branch_valid  = 1'b1;
    branch_target = 8'h40;
    #1;
    chk("t4_br1_mem_en", 32'(mem_en), 32'd0);
    adv();
    branch_target = 8'h60;
    #1;
    chk("t4_br2_valid",  32'(instr_valid), 32'd0);
    chk("t4_br2_mem_en", 32'(mem_en), 32'd0);
    chk("t4_br2_debug",  32'(debug), 32'h40);
    adv();
    branch_valid = 1'b0;
    #1;
    chk("t4_valid_a",  32'(instr_valid), 32'd0);
    chk("t4_addr_a",   32'(mem_addr), 32'h60);
    adv(); #1;
    chk("t4_valid_b",  32'(instr_valid), 32'd0);
    chk("t4_addr_b",   32'(mem_addr), 32'h61);
    for (int k = 0; k < 3; k++) begin
      adv(); #1;
      chk("t4_valid", 32'(instr_valid), 32'd1);
      chk("t4_data",  32'(instr_data), 32'(8'h70 + k));
      chk("t4_pc",    32'(instr_pc), 32'(8'h60 + k));
    end

    // Address wrap from 0xFE
    adv();
    branch_valid  = 1'b1;
    branch_target = 8'hFE;
    #1;
    for (int k = 1; k <= 6; k++) begin
      adv();
      branch_valid = 1'b0;
      #1;
      chk("t5_debug", 32'(debug), 32'(8'(8'hFE + k - 1)));
      chk("t5_valid", 32'(instr_valid), 32'(k >= 3));
      if (k >= 3) begin
        chk("t5_pc",   32'(instr_pc), 32'(8'(8'hFE + k - 3)));
        chk("t5_data", 32'(instr_data), 32'(8'(8'hFE + k - 3 + 8'h10)));
      end
    end

    // Reset mid-stream with the FIFO full
    instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) adv();
    #1;
    chk("t6_full_valid",  32'(instr_valid), 32'd1);
    chk("t6_full_mem_en", 32'(mem_en), 32'd0);
    adv();
    reset = 1'b1;
    #1;
    chk("t6_rst_mem_en", 32'(mem_en), 32'd0);
    adv();
    reset       = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("t6_post_valid", 32'(instr_valid), 32'd0);
    chk("t6_post_en",    32'(mem_en), 32'd1);
    chk("t6_post_addr",  32'(mem_addr), 32'h00);
    adv(); #1;
    chk("t6_valid_1",    32'(instr_valid), 32'd0);
    chk("t6_addr_1",     32'(mem_addr), 32'h01);
    adv(); #1;
    chk("t6_valid_2",    32'(instr_valid), 32'd1);
    chk("t6_data_2",     32'(instr_data), 32'h10);
    chk("t6_pc_2",       32'(instr_pc), 32'h00);
    adv(); #1;
    chk("t6_data_3",     32'(instr_data), 32'h11);
    chk("t6_pc_3",       32'(instr_pc), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
